// File: rtl/share_column_if.sv
// Handshake bundle for share_column_unit: unmasked column in, one lane of
// randomness per transfer in, d-share Boolean-masked column out.
interface share_column_if #(
  parameter int unsigned d = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_col;
  logic                 rnd_valid;
  logic                 rnd_ready;
  logic [8*(d-1)-1:0]   rnd;
  logic                 out_valid;
  logic                 out_ready;
  logic [32*d-1:0]      sh_out;

  modport slave (
    input  in_valid, in_col, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, sh_out
  );

  modport master (
    output in_valid, in_col, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, sh_out
  );
endinterface

// File: rtl/share_column_unit.sv
// Masks one unmasked 32-bit column into d Boolean shares, one byte lane per
// randomness transfer, in the interleaved shared-bus layout.
module share_column_unit #(
  parameter int unsigned d = 2
) (
  input  logic          clk,
  input  logic          syn_rst_n,
  share_column_if.slave col_if
);
  localparam int unsigned LANE_W = 8 * d;
  localparam int unsigned SH_W   = 32 * d;
  localparam int unsigned SH_AW  = $clog2(SH_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHARE = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       col_q, col_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              in_ready_q, in_ready_d;
  logic              rnd_ready_q, rnd_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        byte_c;
  logic [LANE_W-1:0] lane_c;
  logic [SH_AW-1:0]  base_c;

  // Shares of byte lane cnt: shares 0..d-2 are the random bytes, share d-1 absorbs the plaintext
  always_comb begin
    logic acc;
    lane_c = '0;
    acc    = 1'b0;
    byte_c = col_q[{cnt_q, 3'b000} +: 8];
    base_c = SH_AW'(cnt_q) * SH_AW'(LANE_W);
    for (int i = 0; i < 8; i++) begin
      acc = byte_c[i];
      for (int j = 0; j < int'(d) - 1; j++) begin
        lane_c[d*i + j] = col_if.rnd[8*j + i];
        acc             = acc ^ col_if.rnd[8*j + i];
      end
      lane_c[d*i + d - 1] = acc;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    sh_d        = sh_q;
    in_ready_d  = 1'b0;
    rnd_ready_d = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (col_if.in_valid && in_ready_q) begin
          col_d   = col_if.in_col;
          cnt_d   = 2'd0;
          state_d = SHARE;
        end
      end
      SHARE: begin
        if (col_if.rnd_valid && rnd_ready_q) begin
          sh_d[base_c +: LANE_W] = lane_c;
          cnt_d                  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        // Scrub plaintext and shares once the column has left
        if (col_if.out_ready && out_valid_q) begin
          col_d   = '0;
          sh_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    rnd_ready_d = (state_d == SHARE);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      col_q       <= '0;
      sh_q        <= '0;
      in_ready_q  <= 1'b1;
      rnd_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      sh_q        <= sh_d;
      in_ready_q  <= in_ready_d;
      rnd_ready_q <= rnd_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign col_if.in_ready  = in_ready_q;
  assign col_if.rnd_ready = rnd_ready_q;
  assign col_if.out_valid = out_valid_q;
  assign col_if.sh_out    = sh_q;
endmodule

// File: doc/share_column_unit.md
# share_column_unit

Masking-side counterpart of the share recombiners: converts one unmasked 32-bit column into a d-share Boolean-masked column in the core's shared bus layout. Consumes fresh randomness one byte-lane at a time through a valid/ready port. Sits between the unmasked data and key loading path and any masked datapath input that expects `32*d`-bit shared columns. Also drives masked stimulus in benches whose outputs are checked by recombination.

## Interface

Parameters:
- `d`, 2: number of shares; legal values d ≥ 2.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `syn_rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: an unmasked column is present on `in_col`.
- `in_ready` out 1: block accepts a column this cycle.
- `in_col` in 32: unmasked column; byte k = `in_col[8k +: 8]`.
- `rnd_valid` in 1: fresh randomness is present on `rnd`.
- `rnd_ready` out 1: block consumes `rnd` this cycle.
- `rnd` in `8*(d-1)`: randomness for one byte lane; bits `8j +: 8` form random share j, for j = 0..d-2.
- `out_valid` out 1: shared column is valid on `sh_out`.
- `out_ready` in 1: consumer accepts `sh_out`.
- `sh_out` out `32*d`: shared column.
  - Byte k occupies `sh_out[8*d*k +: 8*d]`.
  - Within a byte, share j of bit i is at offset `d*i + j`.

## Operation

- Sharing of byte x with random bytes r0..r(d-2):
  - share j = rj for j < d-1.
  - share d-1 = x ^ r0 ^ … ^ r(d-2).
  - The XOR of all d shares equals x.
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid` & `in_ready`, latch `in_col`, clear the lane counter, go to SHARE.
  - SHARE:
    - `rnd_ready`=1.
    - Each cycle with `rnd_valid`, compute the shares of byte lane `cnt` and write them into the output register slice for that lane. Then `cnt` += 1.
    - When `cnt` was 3 on that transfer, go to OUT.
    - A cycle with `rnd_valid`=0 stalls; no state changes.
  - OUT:
    - `out_valid`=1 and `sh_out` holds steady.
    - On `out_ready`, clear the latched plaintext register and `sh_out` to 0, then go to IDLE.
- `cnt` is 2 bits. It is used only in SHARE; wrap past 3 is not possible.
- Each random bit is used exactly once. `rnd` is never consumed outside SHARE.
- `in_ready` and `rnd_ready` depend only on state, never combinationally on `in_valid` or `rnd_valid`.
- No plaintext bit may appear on `sh_out` except inside share d-1 XORed with randomness. Intermediate lanes not yet written read 0.

## Timing

- Reset (`syn_rst_n`=0 at a clock edge):
  - State = IDLE, `cnt`=0.
  - `in_ready`=1 from the first cycle after reset.
  - `rnd_ready`=0, `out_valid`=0, `sh_out`=0, plaintext register = 0.
- Reset mid-operation, in SHARE or OUT:
  - Abandons the column; nothing is emitted.
  - Registers are cleared as above on that edge.
- Latency with `rnd_valid` held at 1:
  - Accept on edge 0.
  - Lanes 0..3 written on edges 1..4.
  - `out_valid`=1 in the cycle after edge 4.
  - Result: 5 cycles from accept to `out_valid`.
- Minimum throughput: one column per 6 cycles; IDLE costs 1 cycle between columns.
- `in_ready`=0 throughout SHARE and OUT. `in_valid` presented then is held off, not lost.
- `out_valid` stays 1 until `out_ready`. With `out_ready`=1 on the first OUT cycle, `out_valid` is high exactly 1 cycle.

## Test plan

- Reset check:
  - Hold `syn_rst_n`=0 for 3 cycles with all inputs toggling.
  - Required: `in_ready`=1, `rnd_ready`=0, `out_valid`=0, `sh_out`=0; no output transfer.
- Basic sharing, d=2:
  - Stimulus: `in_col`=0x03020100; `rnd` = 0xAA, 0x55, 0xFF, 0x01 on consecutive cycles; `out_ready`=1.
  - Required share 0 lanes: 0xAA, 0x55, 0xFF, 0x01.
  - Required share 1 lanes: 0xAA, 0x54, 0xFD, 0x02.
  - Required: `out_valid` 5 cycles after accept; recombination = 0x03020100.
- Randomness stall:
  - Same stimulus, with `rnd_valid`=0 for 2 cycles between lanes 1 and 2.
  - Required: `rnd_ready` stays 1, no lane advances during the gap, `out_valid` at accept+7, identical `sh_out`.
- Output backpressure:
  - Hold `out_ready`=0 for 4 cycles in OUT while `in_valid`=1 with a second column.
  - Required: `sh_out` stable, `in_ready`=0; the second column is accepted only on the cycle after the `out_ready` transfer.
- Reset mid-SHARE:
  - Assert `syn_rst_n`=0 after lane 1 is written.
  - Required: state IDLE, `sh_out`=0, no `out_valid`; the next column shares correctly from lane 0.
- Random regression, d=2,3,4:
  - 1000 random columns and randomness, with random `rnd_valid`/`out_ready` gaps.
  - Required: every recombined output equals its input in order, and share j<d-1 equals the supplied `rnd` bytes.
